tcpc_transmit_dispatch: RTL

Decodes writes to the TCPC TRANSMIT register and dispatches each command: SOP* message transmissions go to the protocol transmit layer, Hard Reset and Cable Reset go to the hard reset transmission stage as active-low one-cycle requests. It sits directly upstream of the hard reset transmitter, consumes that block's completion alerts, and produces the TransmitSuccessful/Failed/Discarded pulses for the ALERT register. It also handles message retries and runs a completion watchdog.

---
 rtl/tcpc_transmit_dispatch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tcpc_transmit_dispatch.sv
// tcpc_transmit_dispatch
// Decodes TCPC TRANSMIT writes and dispatches SOP* messages to the protocol
// TX layer, or Hard/Cable Reset requests to the hard reset stage. Handles
// message retries, a whole-command completion watchdog, preemption of an SOP
// message by a reset command, and the one-cycle ALERT transmit pulses.
module tcpc_transmit_dispatch #(
   parameter logic [31:0] WAIT_TIMEOUT = 32'd100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       transmit_wr,
   input  logic [7:0] transmit_wdata,
   output logic [7:0] transmit_reg,
   output logic       sop_request,
   output logic [2:0] sop_type,
   input  logic       sop_done,
   input  logic       sop_failed,
   output logic       sop_abort,
   output logic       hard_reset_L,
   output logic       cable_reset_L,
   input  logic       ALERT_TransmitSuccessful,
   input  logic       ALERT_TransmitSOPMessageFailed,
   output logic       alert_tx_success,
   output logic       alert_tx_failed,
   output logic       alert_tx_discarded,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, SOP_REQ, SOP_WAIT, SOP_GAP, HR_REQ, HR_WAIT, REPORT
   } state_t;

   state_t      state;
   logic [1:0]  retries_left;
   logic [31:0] wdog;

   logic [2:0]  wr_type;
   logic        wr_sop;
   logic        wr_hr;
   logic        in_sop;
   logic        preempt;

   // Decode of the incoming write and the reset-preempts-message condition
   always_comb begin
      wr_type = transmit_wdata[2:0];
      wr_sop  = (wr_type <= 3'd4);
      wr_hr   = (wr_type == 3'd5) || (wr_type == 3'd6);
      in_sop  = (state == SOP_REQ) || (state == SOP_WAIT) || (state == SOP_GAP);
      preempt = transmit_wr && wr_hr && in_sop;
   end

   // Command FSM; every output is registered here, pulses default low each cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         transmit_reg       <= 8'h00;
         retries_left       <= 2'd0;
         wdog               <= 32'd0;
         sop_request        <= 1'b0;
         sop_type           <= 3'd0;
         sop_abort          <= 1'b0;
         hard_reset_L       <= 1'b1;
         cable_reset_L      <= 1'b1;
         alert_tx_success   <= 1'b0;
         alert_tx_failed    <= 1'b0;
         alert_tx_discarded <= 1'b0;
         busy               <= 1'b0;
      end else begin
         sop_abort          <= 1'b0;
         hard_reset_L       <= 1'b1;
         cable_reset_L      <= 1'b1;
         alert_tx_success   <= 1'b0;
         alert_tx_failed    <= 1'b0;
         alert_tx_discarded <= 1'b0;

         if (preempt) begin
            // A reset command cancels the in-flight message and takes over;
            // the watchdog restarts for the new command.
            state              <= HR_REQ;
            transmit_reg       <= transmit_wdata;
            wdog               <= WAIT_TIMEOUT;
            sop_request        <= 1'b0;
            sop_abort          <= 1'b1;
            alert_tx_discarded <= 1'b1;
            hard_reset_L       <= (wr_type != 3'd5);
            cable_reset_L      <= (wr_type != 3'd6);
         end else begin
            // Writes while busy are dropped, never queued
            if (transmit_wr && state != IDLE)
               alert_tx_discarded <= 1'b1;

            case (state)
               IDLE: begin
                  if (transmit_wr) begin
                     transmit_reg <= transmit_wdata;
                     retries_left <= transmit_wdata[5:4];
                     wdog         <= WAIT_TIMEOUT;
                     busy         <= 1'b1;
                     if (wr_sop) begin
                        state       <= SOP_REQ;
                        sop_request <= 1'b1;
                        sop_type    <= wr_type;
                     end else if (wr_hr) begin
                        state         <= HR_REQ;
                        hard_reset_L  <= (wr_type != 3'd5);
                        cable_reset_L <= (wr_type != 3'd6);
                     end else begin
                        state           <= REPORT;
                        alert_tx_failed <= 1'b1;
                     end
                  end
               end
               SOP_REQ: state <= SOP_WAIT;
               SOP_GAP: begin
                  state       <= SOP_REQ;
                  sop_request <= 1'b1;
               end
               SOP_WAIT: begin
                  if (sop_done) begin
                     state            <= REPORT;
                     sop_request      <= 1'b0;
                     alert_tx_success <= 1'b1;
                  end else if (sop_failed) begin
                     sop_request <= 1'b0;
                     if (retries_left != 2'd0) begin
                        retries_left <= retries_left - 2'd1;
                        state        <= SOP_GAP;
                     end else begin
                        state           <= REPORT;
                        alert_tx_failed <= 1'b1;
                     end
                  end else if (wdog == 32'd0) begin
                     state           <= REPORT;
                     sop_request     <= 1'b0;
                     sop_abort       <= 1'b1;
                     alert_tx_failed <= 1'b1;
                  end else begin
                     wdog <= wdog - 32'd1;
                  end
               end
               HR_REQ: state <= HR_WAIT;
               HR_WAIT: begin
                  if (ALERT_TransmitSOPMessageFailed) begin
                     state           <= REPORT;
                     alert_tx_failed <= 1'b1;
                  end else if (ALERT_TransmitSuccessful) begin
                     state            <= REPORT;
                     alert_tx_success <= 1'b1;
                  end else if (wdog == 32'd0) begin
                     state           <= REPORT;
                     alert_tx_failed <= 1'b1;
                  end else begin
                     wdog <= wdog - 32'd1;
                  end
               end
               REPORT: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
